// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit sprite controller and its fall physics.
package fruit_pkg;

   localparam int unsigned POS_W     = 11;
   localparam int unsigned SPEED_W   = 8;
   localparam int unsigned TIMER_W   = 16;
   localparam int unsigned SCORE_W   = 8;
   localparam int unsigned FRAC_BITS = 4;

   localparam int FRUIT_APPLE  = 0;
   localparam int FRUIT_BANANA = 1;
   localparam int FRUIT_CHERRY = 2;
   localparam int FRUIT_GRAPE  = 3;

   typedef enum logic [1:0] {
      RESPAWN,
      HANGING,
      FALLING,
      EATEN
   } fruit_state_t;

endpackage

// File: rtl/fruit_fall_physics.sv
// Q4.4 speed integration for a falling fruit: saturating speed, clamped Y step, floor detect.
module fruit_fall_physics
   import fruit_pkg::*;
#(
   parameter int unsigned GRAVITY   = 3,
   parameter int unsigned MAX_SPEED = 96,
   parameter int          FLOOR_Y   = 440
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic                    start_of_frame,
   input  logic signed [POS_W-1:0] cur_y,
   output logic signed [POS_W-1:0] new_y_c,
   output logic                    at_floor_c
);

   localparam int unsigned WIDE_W = POS_W + 1;

   logic [SPEED_W-1:0]        speed_q, speed_d;
   logic [SPEED_W:0]          sum_c;
   logic [SPEED_W-1:0]        next_speed_c;
   logic signed [WIDE_W-1:0]  step_c;
   logic signed [WIDE_W-1:0]  y_sum_c;
   logic signed [WIDE_W-1:0]  y_clamp_c;

   // Speed for this frame is computed first; the Y step uses the updated speed.
   always_comb begin
      sum_c = {1'b0, speed_q} + (SPEED_W+1)'(GRAVITY);
      if (sum_c > (SPEED_W+1)'(MAX_SPEED))
         next_speed_c = SPEED_W'(MAX_SPEED);
      else if (sum_c[SPEED_W])
         next_speed_c = '1;
      else
         next_speed_c = sum_c[SPEED_W-1:0];

      step_c    = $signed(WIDE_W'(next_speed_c >> FRAC_BITS));
      y_sum_c   = $signed({cur_y[POS_W-1], cur_y}) + step_c;
      y_clamp_c = (y_sum_c > $signed(WIDE_W'(1023))) ? $signed(WIDE_W'(1023)) : y_sum_c;
      new_y_c   = y_clamp_c[POS_W-1:0];
      at_floor_c = (new_y_c >= $signed(POS_W'(FLOOR_Y)));

      speed_d = speed_q;
      if (load)
         speed_d = '0;
      else if (en && start_of_frame)
         speed_d = next_speed_c;
   end

   always_ff @(posedge clk) begin
      if (rst) speed_q <= '0;
      else     speed_q <= speed_d;
   end

endmodule

// File: rtl/fruit_controller.sv
// Per-slot fruit sprite FSM: respawn timer, hang/fall/eaten sequencing and score events.
module fruit_controller
   import fruit_pkg::*;
#(
   parameter int unsigned RESPAWN_FRAMES = 120,
   parameter int unsigned GRAVITY        = 3,
   parameter int unsigned MAX_SPEED      = 96,
   parameter int          FLOOR_Y        = 440,
   parameter int unsigned EAT_POINTS     = 10,
   parameter int unsigned ENEMY_POINTS   = 40
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    startOfFrame,
   input  logic signed [POS_W-1:0] spawnX,
   input  logic signed [POS_W-1:0] spawnY,
   input  int                      fruitKind,
   input  logic                    playerHit,
   input  logic                    enemyHit,
   input  logic                    dropCmd,
   output logic signed [POS_W-1:0] topLeftX,
   output logic signed [POS_W-1:0] topLeftY,
   output int                      fruitChoice,
   output logic                    drawFruit,
   output logic                    scorePulse,
   output logic [SCORE_W-1:0]      scoreValue
);

   fruit_state_t             state_q, state_d;
   logic [TIMER_W-1:0]       timer_q, timer_d;
   logic signed [POS_W-1:0]  x_q, x_d, y_q, y_d;
   int                       choice_q, choice_d;
   logic                     draw_q, draw_d;
   logic                     pulse_q, pulse_d;
   logic [SCORE_W-1:0]       value_q, value_d;
   logic                     scored_q, scored_d;
   logic                     spawn_c, falling_c, at_floor_c;
   logic signed [POS_W-1:0]  new_y_c;

   assign falling_c = (state_q == FALLING);

   fruit_fall_physics #(
      .GRAVITY   (GRAVITY),
      .MAX_SPEED (MAX_SPEED),
      .FLOOR_Y   (FLOOR_Y)
   ) u_physics (
      .clk            (clk),
      .rst            (resetN),
      .en             (falling_c),
      .load           (spawn_c),
      .start_of_frame (startOfFrame),
      .cur_y          (y_q),
      .new_y_c        (new_y_c),
      .at_floor_c     (at_floor_c)
   );

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      x_d      = x_q;
      y_d      = y_q;
      choice_d = choice_q;
      draw_d   = draw_q;
      pulse_d  = 1'b0;
      value_d  = '0;
      scored_d = scored_q;
      spawn_c  = 1'b0;

      case (state_q)
         RESPAWN: begin
            draw_d = 1'b0;
            if (startOfFrame) begin
               if (timer_q <= TIMER_W'(1)) begin
                  x_d      = spawnX;
                  y_d      = spawnY;
                  choice_d = fruitKind;
                  draw_d   = 1'b1;
                  spawn_c  = 1'b1;
                  state_d  = HANGING;
               end else begin
                  timer_d = timer_q - TIMER_W'(1);
               end
            end
         end
         HANGING: begin
            if (playerHit) begin
               state_d = EATEN;
               draw_d  = 1'b0;
               pulse_d = 1'b1;
               value_d = SCORE_W'(EAT_POINTS);
            end else if (dropCmd) begin
               state_d  = FALLING;
               scored_d = 1'b0;
            end
         end
         FALLING: begin
            if (startOfFrame) begin
               y_d = new_y_c;
               if (at_floor_c) begin
                  draw_d  = 1'b0;
                  timer_d = TIMER_W'(RESPAWN_FRAMES);
                  state_d = RESPAWN;
               end
            end
            // A hit on the frame-start cycle belongs to the new frame.
            if (enemyHit && (!scored_q || startOfFrame)) begin
               pulse_d = 1'b1;
               value_d = SCORE_W'(ENEMY_POINTS);
            end
            scored_d = startOfFrame ? enemyHit : (scored_q | enemyHit);
         end
         EATEN: begin
            timer_d = TIMER_W'(RESPAWN_FRAMES);
            state_d = RESPAWN;
         end
         default: state_d = RESPAWN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state_q  <= RESPAWN;
         timer_q  <= TIMER_W'(RESPAWN_FRAMES);
         x_q      <= '0;
         y_q      <= '0;
         choice_q <= 0;
         draw_q   <= 1'b0;
         pulse_q  <= 1'b0;
         value_q  <= '0;
         scored_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         x_q      <= x_d;
         y_q      <= y_d;
         choice_q <= choice_d;
         draw_q   <= draw_d;
         pulse_q  <= pulse_d;
         value_q  <= value_d;
         scored_q <= scored_d;
      end
   end

   assign topLeftX    = x_q;
   assign topLeftY    = y_q;
   assign fruitChoice = choice_q;
   assign drawFruit   = draw_q;
   assign scorePulse  = pulse_q;
   assign scoreValue  = value_q;

endmodule

// File: tb/tb_fruit_controller.sv
// Directed and random stimulus for fruit_controller, checked against a behavioural game model.
module tb_fruit_controller;

   localparam int RF = 3;

   logic               clk = 1'b0;
   logic               resetN = 1'b1;
   logic               startOfFrame = 1'b0;
   logic signed [10:0] spawnX = '0;
   logic signed [10:0] spawnY = '0;
   int                 fruitKind = 0;
   logic               playerHit = 1'b0;
   logic               enemyHit = 1'b0;
   logic               dropCmd = 1'b0;
   logic signed [10:0] topLeftX, topLeftY;
   int                 fruitChoice;
   logic               drawFruit, scorePulse;
   logic [7:0]         scoreValue;

   int n_assert = 0;
   int n_fail   = 0;

   // model state: phase of the fruit's life and its observable attributes
   localparam int P_HIDDEN = 0, P_HANG = 1, P_FALL = 2, P_EATEN = 3;
   int m_phase, m_timer, m_speed, m_x, m_y, m_kind, m_draw, m_pulse, m_val, m_scored;

   fruit_controller #(.RESPAWN_FRAMES(RF)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .spawnX(spawnX), .spawnY(spawnY), .fruitKind(fruitKind),
      .playerHit(playerHit), .enemyHit(enemyHit), .dropCmd(dropCmd),
      .topLeftX(topLeftX), .topLeftY(topLeftY), .fruitChoice(fruitChoice),
      .drawFruit(drawFruit), .scorePulse(scorePulse), .scoreValue(scoreValue)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      int ph;
      ph = m_phase;
      m_pulse = 0;
      m_val   = 0;
      if (resetN) begin
         m_phase = P_HIDDEN; m_timer = RF; m_speed = 0;
         m_x = 0; m_y = 0; m_kind = 0; m_draw = 0; m_scored = 0;
         return;
      end
      if (ph == P_HIDDEN) begin
         m_draw = 0;
         if (startOfFrame) begin
            m_timer = m_timer - 1;
            if (m_timer <= 0) begin
               m_x = int'(spawnX); m_y = int'(spawnY); m_kind = fruitKind;
               m_speed = 0; m_draw = 1; m_phase = P_HANG;
            end
         end
      end else if (ph == P_HANG) begin
         if (playerHit) begin
            m_phase = P_EATEN; m_draw = 0; m_pulse = 1; m_val = 10;
         end else if (dropCmd) begin
            m_phase = P_FALL; m_scored = 0;
         end
      end else if (ph == P_FALL) begin
         if (startOfFrame) begin
            m_speed = (m_speed + 3 > 96) ? 96 : m_speed + 3;
            m_y = m_y + m_speed / 16;
            if (m_y > 1023) m_y = 1023;
            if (m_y >= 440) begin
               m_draw = 0; m_phase = P_HIDDEN; m_timer = RF;
            end
         end
         if (enemyHit && (m_scored == 0 || startOfFrame)) begin
            m_pulse = 1; m_val = 40;
         end
         if (startOfFrame) m_scored = enemyHit ? 1 : 0;
         else if (enemyHit) m_scored = 1;
      end else begin
         m_phase = P_HIDDEN; m_timer = RF;
      end
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic sof, input logic ph, input logic eh,
                        input logic dc, input logic rst);
      startOfFrame = sof; playerHit = ph; enemyHit = eh; dropCmd = dc; resetN = rst;
      model_step();
      @(posedge clk);
      #1;
      chk("topLeftX", int'(topLeftX), m_x);
      chk("topLeftY", int'(topLeftY), m_y);
      chk("fruitChoice", fruitChoice, m_kind);
      chk("drawFruit", int'(drawFruit), m_draw);
      chk("scorePulse", int'(scorePulse), m_pulse);
      chk("scoreValue", int'(scoreValue), m_val);
   endtask

   task automatic frame();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int y0;
      m_phase = P_HIDDEN; m_timer = RF; m_speed = 0; m_x = 0; m_y = 0;
      m_kind = 0; m_draw = 0; m_pulse = 0; m_val = 0; m_scored = 0;

      // reset and first spawn
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      chk("rst_draw", int'(drawFruit), 0);
      spawnX = 11'sd100; spawnY = 11'sd50; fruitKind = 2;
      repeat (3) frame();
      chk("t1_draw", int'(drawFruit), 1);
      chk("t1_x", int'(topLeftX), 100);
      chk("t1_y", int'(topLeftY), 50);
      chk("t1_kind", fruitChoice, 2);

      // eaten while hanging
      cycle(0, 1, 0, 0, 0);
      chk("t2_pulse", int'(scorePulse), 1);
      chk("t2_val", int'(scoreValue), 10);
      cycle(0, 0, 0, 0, 0);
      chk("t2_pulse_off", int'(scorePulse), 0);
      chk("t2_hidden", int'(drawFruit), 0);

      // drop ignored while hidden, then respawn and fall
      cycle(0, 0, 0, 1, 0);
      repeat (3) frame();
      chk("t3_respawn", int'(drawFruit), 1);
      cycle(0, 0, 0, 1, 0);
      repeat (4) begin
         frame();
         chk("t3_y_still", int'(topLeftY), 50);
      end
      repeat (30) frame();
      y0 = int'(topLeftY);
      frame();
      chk("t3_max_step", int'(topLeftY) - y0, 6);

      // enemy scoring, one per frame
      cycle(0, 0, 1, 0, 0);
      chk("t4_first", int'(scoreValue), 40);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      chk("t4_dropped", int'(scorePulse), 0);
      frame();
      cycle(0, 0, 1, 0, 0);
      chk("t4_second", int'(scorePulse), 1);

      // reset mid-fall
      cycle(0, 0, 0, 0, 1);
      chk("t6_rst_y", int'(topLeftY), 0);
      chk("t6_rst_draw", int'(drawFruit), 0);
      cycle(0, 0, 0, 0, 0);

      // simultaneous eat and drop; then fall past the floor
      spawnY = 11'sd430;
      repeat (3) frame();
      cycle(0, 1, 0, 1, 0);
      chk("t5_eat_val", int'(scoreValue), 10);
      cycle(0, 0, 0, 0, 0);
      repeat (3) frame();
      cycle(0, 0, 0, 1, 0);
      repeat (14) frame();
      chk("t6_floor", int'(drawFruit), 0);

      // random play
      for (int i = 0; i < 1500; i++) begin
         spawnX    = 11'($urandom_range(0, 639));
         spawnY    = 11'($urandom_range(0, 470));
         fruitKind = int'($urandom_range(0, 3));
         cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 299) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
